// File: rtl/conv1_pkg.sv
// Shared constants, FSM encoding and result-count helper for the Conv1 window sequencer.
// Build option: define CONV1_ZERO_PAD_EN for "same" padding (two leading and two trailing zeros).
package conv1_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_OUT_W  = 8;
    localparam int TAPS       = 5;

`ifdef CONV1_ZERO_PAD_EN
    localparam bit ZERO_PAD   = 1'b1;
`else
    localparam bit ZERO_PAD   = 1'b0;
`endif

    // Samples needed before the first window is complete; the zero preload supplies two.
    localparam int FIRST_FILL = ZERO_PAD ? TAPS - 2 : TAPS;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_CONV = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic int nres(input int frame_len);
        return ZERO_PAD ? frame_len : frame_len - (TAPS - 1);
    endfunction

endpackage

// File: rtl/conv1_window_shift.sv
// Five-entry sliding window; taps[0] is the oldest sample, taps[TAPS-1] the newest.
// clr zero-fills every entry, which doubles as the zero preload for padded frames.
module conv1_window_shift
    import conv1_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic [W-1:0]          din,
    output logic [TAPS-1:0][W-1:0] taps
);

    logic [TAPS-1:0][W-1:0] taps_q;
    logic [TAPS-1:0][W-1:0] taps_d;

    always_comb begin
        taps_d = taps_q;
        if (clr) begin
            taps_d = '0;
        end else if (shift_en) begin
            taps_d = {din, taps_q[TAPS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/conv1_window_ctrl.sv
// Sequencer for the Conv1 5-tap datapath: fills the window, waits CONV_LAT, returns one result per position.
// Build option: CONV1_ZERO_PAD_EN inserts two trailing zero samples and yields FRAME_LEN results.
module conv1_window_ctrl
    import conv1_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int FRAME_LEN = 32,
    parameter int CONV_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] conv_in1,
    output logic [DATA_W-1:0] conv_in2,
    output logic [DATA_W-1:0] conv_in3,
    output logic [DATA_W-1:0] conv_in4,
    output logic [DATA_W-1:0] conv_in5,
    input  logic [OUT_W-1:0]  conv_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output state_e            dbg_state
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

    localparam logic [CW-1:0] FL_C     = CW'(FRAME_LEN);
    localparam logic [CW-1:0] NRES_C   = CW'(nres(FRAME_LEN));
    localparam logic [CW-1:0] FIRST_C  = CW'(FIRST_FILL);
    localparam logic [LW-1:0] LAT_LAST = LW'(CONV_LAT - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     sc_q, sc_d;
    logic [CW-1:0]     rc_q, rc_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [OUT_W-1:0]  m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              win_clr;
    logic              win_shift;
    logic [DATA_W-1:0] win_din;
    logic [TAPS-1:0][DATA_W-1:0] taps;

    conv1_window_shift #(
        .W (DATA_W)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (win_clr),
        .shift_en (win_shift),
        .din      (win_din),
        .taps     (taps)
    );

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // m_valid/m_data/m_last hold until that edge, and s_ready is only high in FILL below FRAME_LEN.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        rc_d      = rc_q;
        lat_d     = lat_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        win_clr   = 1'b0;
        win_shift = 1'b0;
        win_din   = s_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_clr = 1'b1;
                    sc_d    = '0;
                    rc_d    = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                lat_d = '0;
                if (sc_q < FL_C) begin
                    if (s_valid && s_ready_q) begin
                        win_shift = 1'b1;
                        sc_d      = sc_q + 1'b1;
                        if (sc_d >= FIRST_C) begin
                            state_d = ST_CONV;
                        end
                    end
`ifdef CONV1_ZERO_PAD_EN
                end else begin
                    // Source exhausted: each trailing window entry pulls in one internal zero.
                    win_shift = 1'b1;
                    win_din   = '0;
                    state_d   = ST_CONV;
`endif
                end
            end
            ST_CONV: begin
                if (lat_q == LAT_LAST) begin
                    m_data_d  = conv_out;
                    m_valid_d = 1'b1;
                    m_last_d  = (rc_q == NRES_C - 1'b1);
                    state_d   = ST_OUT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    rc_d      = rc_q + 1'b1;
                    state_d   = (rc_d == NRES_C) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d = (state_d == ST_FILL) && (sc_d < FL_C);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sc_q      <= '0;
            rc_q      <= '0;
            lat_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            rc_q      <= rc_d;
            lat_q     <= lat_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign conv_in1  = taps[0];
    assign conv_in2  = taps[1];
    assign conv_in3  = taps[2];
    assign conv_in4  = taps[3];
    assign conv_in5  = taps[4];
    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv1_window_ctrl.sv
// Bench for conv1_window_ctrl with FRAME_LEN = 8 and a weighted-sum stand-in for Conv1.
// Honours CONV1_ZERO_PAD_EN: the reference model pads the sample stream with two zeros on each side.
module tb_conv1_window_ctrl;
    import conv1_pkg::*;

    localparam int FL  = 8;
    localparam int LAT = 1;
    localparam int DW  = 4;
    localparam int OW  = 8;
`ifdef CONV1_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
    localparam int NR  = FL;
`else
    localparam bit PAD = 1'b0;
    localparam int NR  = FL - 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [DW-1:0] conv_in1, conv_in2, conv_in3, conv_in4, conv_in5;
    logic [OW-1:0] conv_out;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    state_e        dbg_state;

    logic          stub_ovr;
    logic [OW-1:0] stub_val;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [OW:0]   exp_q[$];
    logic [OW:0]   got_q[$];
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] dir_smp[$];
    logic [DW-1:0] rest_smp[$];
    logic [DW-1:0] rnd_smp[$];
    int            n_before;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    conv1_window_ctrl #(
        .DATA_W    (DW),
        .OUT_W     (OW),
        .FRAME_LEN (FL),
        .CONV_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .conv_in1  (conv_in1),
        .conv_in2  (conv_in2),
        .conv_in3  (conv_in3),
        .conv_in4  (conv_in4),
        .conv_in5  (conv_in5),
        .conv_out  (conv_out),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Stand-in Conv1: position-weighted sum, combinational so it is ready within one cycle.
    function automatic logic [OW-1:0] dot5(input logic [DW-1:0] a, b, c, d, e);
        return OW'(a) + OW'(b) * OW'(2) + OW'(c) * OW'(3) + OW'(d) * OW'(4) + OW'(e) * OW'(5);
    endfunction

    assign conv_out = stub_ovr ? stub_val : dot5(conv_in1, conv_in2, conv_in3, conv_in4, conv_in5);

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) acc_q.push_back(s_data);
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
            if (done) done_cnt++;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_window"}, {conv_in1, conv_in2, conv_in3, conv_in4, conv_in5}, 0);
    endtask

    // Reference: result k is the weighted sum of padded samples k..k+4; last flag on k == NR-1.
    task automatic build_exp(input logic [DW-1:0] smp[$], input int first_k);
        logic [DW-1:0] p[$];
        exp_q.delete();
        if (PAD) begin
            p.push_back('0);
            p.push_back('0);
        end
        for (int i = 0; i < FL; i++) p.push_back(smp[i]);
        if (PAD) begin
            p.push_back('0);
            p.push_back('0);
        end
        for (int k = first_k; k < NR; k++)
            exp_q.push_back({(k == NR - 1), dot5(p[k], p[k+1], p[k+2], p[k+3], p[k+4])});
    endtask

    task automatic compare_results(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_result"}, got_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic compare_accepted(input string tag, input logic [DW-1:0] smp[$]);
        chk({tag, "_accepted"}, acc_q.size(), FL);
        for (int i = 0; i < FL && i < acc_q.size(); i++)
            chk({tag, "_sample"}, acc_q[i], smp[i]);
    endtask

    // Offers smp in order (extras beyond FRAME_LEN stay offered) until done or the cycle budget runs out.
    task automatic stream(input logic [DW-1:0] smp[$], input int vld_pct, input int rdy_pct,
                          input bit poke_start);
        int idx = 0;
        bit fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            s_valid = (idx < smp.size()) && ($urandom_range(99) < vld_pct);
            s_data  = (idx < smp.size()) ? smp[idx] : '0;
            m_ready = ($urandom_range(99) < rdy_pct);
            start   = poke_start && ($urandom_range(7) == 0);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            if (done) fin = 1'b1;
            tick();
        end
        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("stream_done_seen", fin, 1);
    endtask

    task automatic run_random_frame(input int vld_pct, input int rdy_pct);
        rnd_smp.delete();
        for (int i = 0; i < FL + 1; i++) rnd_smp.push_back(DW'($urandom_range(15)));
        acc_q.delete();
        got_q.delete();
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rnd_busy", busy, 1);
        stream(rnd_smp, vld_pct, rdy_pct, 1'b1);
        tick();
        tick();
        build_exp(rnd_smp, 0);
        compare_results("rnd");
        compare_accepted("rnd", rnd_smp);
        chk("rnd_done_pulses", done_cnt, 1);
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_ready", s_ready, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        stub_ovr = 1'b0;
        stub_val = '0;
        dir_smp  = '{4'd14, 4'd7, 4'd10, 4'd9, 4'd2, 4'd4, 4'd11, 4'd6};
        rest_smp = '{4'd11, 4'd6, 4'd13};

        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        acc_q.delete();
        got_q.delete();
        done_cnt = 0;

`ifndef CONV1_ZERO_PAD_EN
        // First window and its result latency.
        stub_ovr = 1'b1;
        stub_val = 8'hA5;
        m_ready  = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = dir_smp[i];
            chk("fill_ready", s_ready, 1);
            tick();
        end
        s_valid = 1'b0;
        chk("conv_ready_low", s_ready, 0);
        chk("window1", {conv_in1, conv_in2, conv_in3, conv_in4, conv_in5},
            {4'd14, 4'd7, 4'd10, 4'd9, 4'd2});
        for (int c = 0; c < LAT; c++) begin
            chk("valid_early", m_valid, 0);
            tick();
        end
        chk("valid_on_time", m_valid, 1);
        chk("res1_data", m_data, 8'hA5);
        chk("res1_last", m_last, 0);

        // Next window needs exactly one more sample; offered during OUT it must stall.
        s_valid = 1'b1;
        s_data  = dir_smp[5];
        chk("out_ready_low", s_ready, 0);
        tick();
        chk("res1_consumed", m_valid, 0);
        chk("fill2_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("window2", {conv_in1, conv_in2, conv_in3, conv_in4, conv_in5},
            {4'd7, 4'd10, 4'd9, 4'd2, 4'd4});
        repeat (LAT) tick();
        chk("res2_valid", m_valid, 1);

        // Backpressure: result must hold while the Conv1 output and the source change.
        stub_val = 8'h3C;
        s_valid  = 1'b1;
        s_data   = dir_smp[6];
        for (int c = 0; c < 10; c++) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, 8'hA5);
            chk("hold_ready", s_ready, 0);
            tick();
        end
        n_before = got_q.size();
        m_ready  = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("one_handshake", got_q.size(), n_before + 1);
        chk("after_release_valid", m_valid, 0);

        // Finish the frame (with a ninth sample offered) and check the tail results.
        stub_ovr = 1'b0;
        got_q.delete();
        stream(rest_smp, 100, 70, 1'b1);
        tick();
        build_exp(dir_smp, 2);
        compare_results("dir");
        compare_accepted("dir", dir_smp);
        chk("dir_done_pulses", done_cnt, 1);
        chk("dir_idle_busy", busy, 0);
`endif

        // Reset mid-frame after three samples; start in the reset cycle must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = DW'($urandom_range(15));
            tick();
        end
        rst_n   = 1'b0;
        start   = 1'b1;
        m_ready = 1'b1;
        tick();
        chk_zero("midreset");
        rst_n   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        chk("midreset_stays_idle", busy, 0);

        // Randomized frames, fresh window after the reset, with busy-time start pokes.
        run_random_frame(100, 100);
        run_random_frame(60, 40);
        run_random_frame(30, 80);
        run_random_frame(80, 20);
        run_random_frame(50, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
